// File: rtl/prior_sel_tree.sv
// N-channel priority selector: registered comparator tree reducing (valid, priority, index)
// candidates to a single winner, with optional multi-beat accumulation before the output register.
module prior_sel_tree #(
    parameter int N_CH    = 8,
    parameter int PRIOR_W = 8,
    parameter int INDEX_W = 8,
    parameter bit TIE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_beat,
    input  logic                        in_last,
    input  logic [N_CH-1:0]             in_valid,
    input  logic [N_CH*PRIOR_W-1:0]     in_prior,
    input  logic [N_CH*INDEX_W-1:0]     in_index,
    input  logic                        acc_en,
    output logic                        out_valid,
    output logic                        out_hit,
    output logic [PRIOR_W-1:0]          out_prior,
    output logic [INDEX_W-1:0]          out_index,
    output logic [$clog2(N_CH)-1:0]     out_chan
);

    localparam int CH_W   = $clog2(N_CH);
    localparam int N_NODE = N_CH - 1;

    typedef struct packed {
        logic               vld;
        logic [PRIOR_W-1:0] prior;
        logic [INDEX_W-1:0] index;
        logic [CH_W-1:0]    chan;
    } cand_t;

    // 'a' is the lower channel or the older beat; 'b' wins ties only when TIE_LOW=0.
    function automatic cand_t merge(input cand_t a, input cand_t b);
        cand_t w_res;
        logic  w_take_b;
        w_take_b  = b.vld && (!a.vld || (b.prior > a.prior) ||
                              ((b.prior == a.prior) && !TIE_LOW));
        w_res     = w_take_b ? b : a;
        w_res.vld = a.vld | b.vld;
        return w_res;
    endfunction

    cand_t           w_leaf [N_CH];
    cand_t           w_nxt  [N_NODE];
    cand_t           r_node [N_NODE];
    logic [CH_W-1:0] r_beat_sr;
    logic [CH_W-1:0] r_last_sr;

    cand_t              r_acc;
    cand_t              w_root;
    cand_t              w_merged;
    logic               w_root_beat;
    logic               w_root_last;
    logic               r_out_valid;
    logic               r_out_hit;
    logic [PRIOR_W-1:0] r_out_prior;
    logic [INDEX_W-1:0] r_out_index;
    logic [CH_W-1:0]    r_out_chan;

    // NOTE: combinational blocks use blocking '=' and assign every field on every pass, so no latch is inferred.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_leaf[c].vld   = in_beat & in_valid[c];
            w_leaf[c].prior = in_prior[c*PRIOR_W +: PRIOR_W];
            w_leaf[c].index = in_index[c*INDEX_W +: INDEX_W];
            w_leaf[c].chan  = CH_W'(c);
        end
    end

    // Heap layout: node k has children 2k+1 / 2k+2; indices >= N_NODE are leaves in channel order.
    for (genvar k = 0; k < N_NODE; k++) begin : g_node
        localparam int LA = 2 * k + 1;
        localparam int LB = 2 * k + 2;
        cand_t w_a;
        cand_t w_b;
        if (LA >= N_NODE) begin : g_a_leaf
            assign w_a = w_leaf[LA - N_NODE];
        end else begin : g_a_node
            assign w_a = r_node[LA];
        end
        if (LB >= N_NODE) begin : g_b_leaf
            assign w_b = w_leaf[LB - N_NODE];
        end else begin : g_b_node
            assign w_b = r_node[LB];
        end
        assign w_nxt[k] = merge(w_a, w_b);
    end

    // NOTE: state uses non-blocking '<=' so every level samples its children's pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_NODE; k++) r_node[k] <= '0;
            r_beat_sr <= '0;
            r_last_sr <= '0;
        end else begin
            for (int k = 0; k < N_NODE; k++) begin
                if (w_nxt[k].vld) r_node[k] <= w_nxt[k];
                else              r_node[k].vld <= 1'b0;
            end
            r_beat_sr[0] <= in_beat;
            r_last_sr[0] <= in_beat & in_last;
            for (int s = 1; s < CH_W; s++) begin
                r_beat_sr[s] <= r_beat_sr[s-1];
                r_last_sr[s] <= r_last_sr[s-1];
            end
        end
    end

    assign w_root      = r_node[0];
    assign w_root_beat = r_beat_sr[CH_W-1];
    assign w_root_last = r_last_sr[CH_W-1];
    assign w_merged    = merge(r_acc, w_root);

    // With acc_en low the accumulator is held empty, so partial state is dropped and
    // a following single-beat lookup cannot see stale candidates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_prior <= '0;
            r_out_index <= '0;
            r_out_chan  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (!acc_en) begin
                r_acc <= '0;
                if (w_root_beat) begin
                    r_out_valid <= 1'b1;
                    r_out_hit   <= w_root.vld;
                    if (w_root.vld) begin
                        r_out_prior <= w_root.prior;
                        r_out_index <= w_root.index;
                        r_out_chan  <= w_root.chan;
                    end
                end
            end else if (w_root_beat) begin
                if (w_root_last) begin
                    r_acc       <= '0;
                    r_out_valid <= 1'b1;
                    r_out_hit   <= w_merged.vld;
                    if (w_merged.vld) begin
                        r_out_prior <= w_merged.prior;
                        r_out_index <= w_merged.index;
                        r_out_chan  <= w_merged.chan;
                    end
                end else if (w_root.vld) begin
                    r_acc <= w_merged;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_hit   = r_out_hit;
    assign out_prior = r_out_prior;
    assign out_index = r_out_index;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_prior_sel_tree.sv
// Directed bench for prior_sel_tree (N_CH=4): one instance per tie-break polarity,
// both driven by the same beats and checked against hand-computed results.
module tb_prior_sel_tree;

    logic        clk;
    logic        rst_n;
    logic        in_beat;
    logic        in_last;
    logic [3:0]  in_valid;
    logic [31:0] in_prior;
    logic [31:0] in_index;
    logic        acc_en;

    logic       lo_valid, lo_hit;
    logic [7:0] lo_prior, lo_index;
    logic [1:0] lo_chan;
    logic       hi_valid, hi_hit;
    logic [7:0] hi_prior, hi_index;
    logic [1:0] hi_chan;

    int n_checks = 0;
    int n_errors = 0;

    prior_sel_tree #(.N_CH(4), .PRIOR_W(8), .INDEX_W(8), .TIE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .in_beat(in_beat), .in_last(in_last),
        .in_valid(in_valid), .in_prior(in_prior), .in_index(in_index), .acc_en(acc_en),
        .out_valid(lo_valid), .out_hit(lo_hit), .out_prior(lo_prior),
        .out_index(lo_index), .out_chan(lo_chan)
    );

    prior_sel_tree #(.N_CH(4), .PRIOR_W(8), .INDEX_W(8), .TIE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .in_beat(in_beat), .in_last(in_last),
        .in_valid(in_valid), .in_prior(in_prior), .in_index(in_index), .acc_en(acc_en),
        .out_valid(hi_valid), .out_hit(hi_hit), .out_prior(hi_prior),
        .out_index(hi_index), .out_chan(hi_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] p4(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input bit sel_hi, input string tag, input int v, input int h,
                             input int p, input int i, input int c);
        string t;
        t = {tag, sel_hi ? "/tie_hi" : "/tie_lo"};
        check({t, ".valid"}, sel_hi ? hi_valid : lo_valid, v);
        check({t, ".hit"},   sel_hi ? hi_hit   : lo_hit,   h);
        check({t, ".prior"}, sel_hi ? hi_prior : lo_prior, p);
        check({t, ".index"}, sel_hi ? hi_index : lo_index, i);
        check({t, ".chan"},  sel_hi ? hi_chan  : lo_chan,  c);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "/tie_lo.valid"}, lo_valid, 0);
        check({tag, "/tie_hi.valid"}, hi_valid, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic last, input logic [3:0] vld,
                         input logic [31:0] prior, input logic [31:0] index);
        in_beat  = 1'b1;
        in_last  = last;
        in_valid = vld;
        in_prior = prior;
        in_index = index;
    endtask

    // Idle cycles present attractive garbage that must be ignored without in_beat.
    task automatic idle();
        in_beat  = 1'b0;
        in_last  = 1'b1;
        in_valid = 4'hF;
        in_prior = 32'hFFFF_FFFF;
        in_index = 32'hEEEE_EEEE;
    endtask

    initial begin
        rst_n  = 1'b0;
        acc_en = 1'b0;
        idle();
        step();
        step();
        check_out(0, "reset", 0, 0, 0, 0, 0);
        check_out(1, "reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();

        // Single beat, all valid, distinct priorities.
        drive(0, 4'hF, p4(10, 40, 30, 20), p4(1, 2, 3, 4));
        step();
        idle();
        step();
        check_quiet("basic_early");
        step();
        check_out(0, "basic", 1, 1, 40, 2, 1);
        check_out(1, "basic", 1, 1, 40, 2, 1);
        step();
        check_quiet("basic_once");

        // Equal priorities on ch1 and ch3.
        drive(0, 4'hF, p4(10, 50, 20, 50), p4(11, 12, 13, 14));
        step();
        idle();
        step();
        step();
        check_out(0, "tie", 1, 1, 50, 12, 1);
        check_out(1, "tie", 1, 1, 50, 14, 3);

        // Miss holds the previous result; following hit on ch2 only.
        drive(0, 4'h0, p4(99, 99, 99, 99), p4(1, 1, 1, 1));
        step();
        drive(0, 4'b0100, p4(200, 200, 7, 200), p4(0, 0, 9, 0));
        step();
        idle();
        step();
        check_out(0, "miss", 1, 0, 50, 12, 1);
        check_out(1, "miss", 1, 0, 50, 14, 3);
        step();
        check_out(0, "hit", 1, 1, 7, 9, 2);
        check_out(1, "hit", 1, 1, 7, 9, 2);

        // Accumulate over three beats: best 20, 60 (idx 6, ch2), 60 (idx 7, ch1, last).
        acc_en = 1'b1;
        drive(0, 4'b1001, p4(20, 0, 0, 3), p4(5, 0, 0, 33));
        step();
        drive(0, 4'b0100, p4(0, 0, 60, 0), p4(0, 0, 6, 0));
        step();
        drive(1, 4'b0010, p4(0, 60, 0, 0), p4(0, 7, 0, 0));
        step();
        idle();
        check_quiet("acc_beat1");
        step();
        check_quiet("acc_beat2");
        step();
        check_out(0, "acc", 1, 1, 60, 6, 2);
        check_out(1, "acc", 1, 1, 60, 7, 1);
        step();
        check_quiet("acc_once");

        // Back-to-back lookups: {80, 90 last} then {10 last}.
        drive(0, 4'b0010, p4(0, 80, 0, 0), p4(0, 20, 0, 0));
        step();
        drive(1, 4'b0001, p4(90, 0, 0, 0), p4(21, 0, 0, 0));
        step();
        drive(1, 4'b1000, p4(0, 0, 0, 10), p4(0, 0, 0, 22));
        step();
        idle();
        check_quiet("b2b_first");
        step();
        check_out(0, "b2b_a", 1, 1, 90, 21, 0);
        check_out(1, "b2b_a", 1, 1, 90, 21, 0);
        step();
        check_out(0, "b2b_b", 1, 1, 10, 22, 3);
        check_out(1, "b2b_b", 1, 1, 10, 22, 3);
        step();
        check_quiet("b2b_end");

        // Partial accumulation discarded when acc_en drops.
        drive(0, 4'b0001, p4(200, 0, 0, 0), p4(30, 0, 0, 0));
        step();
        idle();
        step();
        step();
        check_quiet("partial");
        step();
        acc_en = 1'b0;
        step();
        drive(0, 4'b0100, p4(0, 0, 5, 0), p4(0, 0, 44, 0));
        step();
        idle();
        step();
        step();
        check_out(0, "drop", 1, 1, 5, 44, 2);
        step();
        acc_en = 1'b1;
        drive(1, 4'b0010, p4(0, 6, 0, 0), p4(0, 45, 0, 0));
        step();
        idle();
        step();
        step();
        check_out(0, "reacc", 1, 1, 6, 45, 1);
        check_out(1, "reacc", 1, 1, 6, 45, 1);

        // Reset for one cycle while two beats are in the tree.
        acc_en = 1'b0;
        drive(0, 4'hF, p4(100, 1, 1, 1), p4(50, 0, 0, 0));
        step();
        drive(0, 4'hF, p4(1, 1, 1, 101), p4(0, 0, 0, 51));
        step();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_out(0, "rst_mid", 0, 0, 0, 0, 0);
        check_out(1, "rst_mid", 0, 0, 0, 0, 0);
        step();
        check_out(0, "rst_after1", 0, 0, 0, 0, 0);
        check_out(1, "rst_after1", 0, 0, 0, 0, 0);
        step();
        check_quiet("rst_after2");
        drive(0, 4'b1000, p4(0, 0, 0, 77), p4(0, 0, 0, 66));
        step();
        idle();
        step();
        check_quiet("fresh_early");
        step();
        check_out(0, "fresh", 1, 1, 77, 66, 3);
        check_out(1, "fresh", 1, 1, 77, 66, 3);
        step();
        check_quiet("fresh_once");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
